fir_filter: RTL and testbench

Eleven-tap, 32-bit signed FIR filter with an AXI4-Lite-style configuration port and AXI4-Stream input/output. Software writes the sample count and tap coefficients, starts the block, streams samples in on `ss_*` and collects filtered results on `sm_*`. It sits between a stream DMA/host and downstream logic, with control and status readable over the lite port.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_axil_cfg.sv | 117 +++++++++++
 rtl/fir_filter.sv | 178 +++++++++++++++++
 tb/tb_fir_filter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: register map, tap count and FSM encoding for fir_filter.
// FIR_SAT_EN (optional) selects saturating accumulation in the core.
package fir_pkg;

    localparam int TAP_NUM = 11;

    localparam logic [11:0] ADDR_CTRL = 12'h000;
    localparam logic [11:0] ADDR_LEN  = 12'h010;
    localparam logic [11:0] ADDR_TAP  = 12'h020;

    localparam int ST_START = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_IDLE  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN,
        S_MAC,
        S_OUT
    } state_t;

endpackage

// File: rtl/fir_axil_cfg.sv
// fir_axil_cfg: lite write/read handshakes, tap and length registers,
// and control/status readback for fir_filter.
module fir_axil_cfg
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                           axis_clk,
    input  logic                           axis_rst_n,
    input  logic                           awvalid,
    input  logic [pADDR_WIDTH-1:0]         awaddr,
    input  logic                           wvalid,
    input  logic [pDATA_WIDTH-1:0]         wdata,
    output logic                           awready,
    output logic                           wready,
    input  logic                           arvalid,
    input  logic [pADDR_WIDTH-1:0]         araddr,
    input  logic                           rready,
    output logic                           arready,
    output logic                           rvalid,
    output logic [pDATA_WIDTH-1:0]         rdata,
    input  logic                           idle,
    input  logic                           done,
    output logic                           sw_start,
    output logic [pDATA_WIDTH-1:0]         data_length,
    output logic [TAP_NUM*pDATA_WIDTH-1:0] taps_flat
);

    logic                   wr;
    logic                   len_wr;
    logic                   tap_wr;
    logic [3:0]             wr_idx;
    logic [3:0]             rd_idx;
    logic                   rd_ctrl;
    logic                   rd_len;
    logic                   rd_tap;
    logic [pDATA_WIDTH-1:0] rd_mux;
    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] tap_q [TAP_NUM];

    assign wr       = awvalid & wvalid;
    assign awready  = wr;
    assign wready   = wr;
    assign wr_idx   = awaddr[3:0];
    assign rd_idx   = araddr[3:0];

    assign sw_start = wr && (awaddr == pADDR_WIDTH'(ADDR_CTRL))
                      && wdata[ST_START];
    assign len_wr   = wr && idle && (awaddr == pADDR_WIDTH'(ADDR_LEN));
    assign tap_wr   = wr && idle && (wr_idx < 4'(TAP_NUM))
                      && ({awaddr[pADDR_WIDTH-1:4], 4'h0}
                          == pADDR_WIDTH'(ADDR_TAP));

    assign rd_ctrl  = (araddr == pADDR_WIDTH'(ADDR_CTRL));
    assign rd_len   = (araddr == pADDR_WIDTH'(ADDR_LEN));
    assign rd_tap   = (rd_idx < 4'(TAP_NUM))
                      && ({araddr[pADDR_WIDTH-1:4], 4'h0}
                          == pADDR_WIDTH'(ADDR_TAP));

    assign data_length = len_q;

    always_comb begin
        for (int i = 0; i < TAP_NUM; i++)
            taps_flat[i*pDATA_WIDTH +: pDATA_WIDTH] = tap_q[i];
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q <= '0;
            for (int i = 0; i < TAP_NUM; i++)
                tap_q[i] <= '0;
        end else begin
            if (len_wr)
                len_q <= wdata;
            for (int i = 0; i < TAP_NUM; i++)
                if (tap_wr && wr_idx == 4'(i))
                    tap_q[i] <= wdata;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            rd_ctrl: begin
                rd_mux[ST_DONE] = done;
                rd_mux[ST_IDLE] = idle;
            end
            rd_len: rd_mux = len_q;
            rd_tap: begin
                for (int i = 0; i < TAP_NUM; i++)
                    if (rd_idx == 4'(i))
                        rd_mux = tap_q[i];
            end
            default: rd_mux = '0;
        endcase
    end

    // arready is registered so it stays low through reset
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_mux;
        end else if (rvalid && rready) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
        end else if (!rvalid) begin
            arready <= 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter.sv
// fir_filter: 11-tap FIR core, one MAC per cycle, stream in/out.
// Define FIR_SAT_EN for saturating accumulation.
module fir_filter
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   awready,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rready,
    output logic                   arready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   ap_start,
    output logic                   ap_done
);

    localparam int DW = pDATA_WIDTH;

    state_t                   state;
    state_t                   state_nx;
    logic                     idle;
    logic                     sw_start;
    logic                     start_go;
    logic                     in_hs;
    logic                     out_hs;
    logic                     last_out;
    logic                     mac_end;
    logic                     unused_tlast;
    logic [3:0]               mac_k;
    logic [DW-1:0]            data_length;
    logic [DW-1:0]            out_cnt;
    logic [DW-1:0]            acc;
    logic [DW-1:0]            acc_next;
    logic [DW-1:0]            prod;
    logic [DW-1:0]            cur_tap;
    logic [DW-1:0]            cur_x;
    logic [DW-1:0]            hist [TAP_NUM];
    logic [TAP_NUM*DW-1:0]    taps_flat;

    fir_axil_cfg #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_cfg (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .awready     (awready),
        .wready      (wready),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .rready      (rready),
        .arready     (arready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .idle        (idle),
        .done        (ap_done),
        .sw_start    (sw_start),
        .data_length (data_length),
        .taps_flat   (taps_flat)
    );

    assign unused_tlast = ss_tlast;

    assign idle      = (state == S_IDLE);
    assign start_go  = idle & (ap_start | sw_start);
    assign ss_tready = (state == S_IN);
    assign sm_tvalid = (state == S_OUT);
    assign in_hs     = ss_tvalid & ss_tready;
    assign out_hs    = sm_tvalid & sm_tready;
    assign last_out  = (out_cnt == data_length);
    assign sm_tlast  = sm_tvalid & last_out;
    assign mac_end   = (mac_k == 4'(TAP_NUM-1));

    always_comb begin
        cur_tap = '0;
        cur_x   = '0;
        for (int i = 0; i < TAP_NUM; i++) begin
            if (mac_k == 4'(i)) begin
                cur_tap = taps_flat[i*DW +: DW];
                cur_x   = hist[i];
            end
        end
    end

    assign prod = cur_tap * cur_x;

`ifdef FIR_SAT_EN
    logic [DW:0] sum_w;
    assign sum_w = {acc[DW-1], acc} + {prod[DW-1], prod};
    always_comb begin
        acc_next = sum_w[DW-1:0];
        if (sum_w[DW] != sum_w[DW-1])
            acc_next = sum_w[DW] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}};
    end
`else
    assign acc_next = acc + prod;
`endif

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start_go && data_length != '0) state_nx = S_IN;
            S_IN:   if (ss_tvalid) state_nx = S_MAC;
            S_MAC:  if (mac_end) state_nx = S_OUT;
            S_OUT:  if (sm_tready) state_nx = last_out ? S_IDLE : S_IN;
            default: state_nx = S_IDLE;
        endcase
    end

    // out_cnt holds the number of the output currently being produced
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < TAP_NUM; i++)
                hist[i] <= '0;
            acc      <= '0;
            mac_k    <= '0;
            out_cnt  <= '0;
            sm_tdata <= '0;
            ap_done  <= 1'b0;
        end else begin
            ap_done <= (start_go && data_length == '0)
                       || (out_hs && last_out);
            if (start_go) begin
                for (int i = 0; i < TAP_NUM; i++)
                    hist[i] <= '0;
                out_cnt <= DW'(1);
            end
            if (in_hs) begin
                hist[0] <= ss_tdata;
                for (int i = 1; i < TAP_NUM; i++)
                    hist[i] <= hist[i-1];
                acc   <= '0;
                mac_k <= '0;
            end
            if (state == S_MAC) begin
                if (mac_end) begin
                    sm_tdata <= acc_next;
                end else begin
                    acc   <= acc_next;
                    mac_k <= mac_k + 4'd1;
                end
            end
            if (out_hs)
                out_cnt <= out_cnt + DW'(1);
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: randomized stream/lite stimulus against a
// convolution reference model of the 11-tap filter.
`timescale 1ns/1ps
module tb_fir_filter;

    localparam int NT   = 11;
    localparam int WMAX = 400;

    logic        axis_clk   = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0;
    logic [11:0] awaddr  = '0;
    logic        wvalid  = 1'b0;
    logic [31:0] wdata   = '0;
    logic        awready;
    logic        wready;
    logic        arvalid = 1'b0;
    logic [11:0] araddr  = '0;
    logic        rready  = 1'b0;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata  = '0;
    logic        ss_tlast  = 1'b0;
    logic        ss_tready;
    logic        sm_tready = 1'b0;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        ap_start = 1'b0;
    logic        ap_done;

    int     n_vec = 0;
    int     n_err = 0;
    int     stim[$];
    int     h[NT];
    int     done_cnt = 0;
    longint cyc = 0;
    longint hs_cyc[$];

    fir_filter dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .awvalid    (awvalid),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .awready    (awready),
        .wready     (wready),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .rready     (rready),
        .arready    (arready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tready  (sm_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .ap_start   (ap_start),
        .ap_done    (ap_done)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        cyc++;
        if (ss_tvalid && ss_tready) hs_cyc.push_back(cyc);
        if (ap_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fir_ref(input int n);
        int acc = 0;
        for (int k = 0; k < NT; k++) begin
            if (n - k >= 0) begin
`ifdef FIR_SAT_EN
                longint s = longint'(acc) + longint'(h[k] * stim[n-k]);
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                acc = int'(s);
`else
                acc = acc + h[k] * stim[n-k];
`endif
            end
        end
        return acc;
    endfunction

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d;
        @(negedge axis_clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        int to;
        to = 0;
        arvalid = 1'b1; araddr = a;
        while (!arready && to < 50) begin @(negedge axis_clk); to++; end
        @(negedge axis_clk);
        arvalid = 1'b0; rready = 1'b1;
        while (!rvalid && to < 50) begin @(negedge axis_clk); to++; end
        if (to >= 50) check("rd_timeout", to, 0);
        d = rdata;
        @(negedge axis_clk);
        rready = 1'b0;
    endtask

    task automatic start_pulse(input bit sw);
        if (sw) begin
            axil_write(12'h000, 32'h1);
        end else begin
            ap_start = 1'b1;
            @(negedge axis_clk);
            ap_start = 1'b0;
        end
    endtask

    task automatic drive_in(input int n, input int gap);
        int to;
        for (int i = 0; i < n; i++) begin
            to = 0;
            ss_tvalid = 1'b0;
            repeat ($urandom_range(0, gap)) @(negedge axis_clk);
            ss_tvalid = 1'b1;
            ss_tdata  = stim[i];
            while (!ss_tready && to < WMAX) begin
                @(negedge axis_clk); to++;
            end
            if (to >= WMAX) begin check("in_timeout", to, 0); break; end
            @(negedge axis_clk);
        end
        ss_tvalid = 1'b0;
    endtask

    task automatic collect_out(input int exp_y[$], input bit bp);
        int to;
        int n = exp_y.size();
        for (int j = 0; j < n; j++) begin
            to = 0;
            sm_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(sm_tvalid && sm_tready) && to < WMAX) begin
                @(negedge axis_clk);
                sm_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                to++;
            end
            if (to >= WMAX) begin check("out_timeout", to, 0); break; end
            check($sformatf("y[%0d]", j), sm_tdata, exp_y[j]);
            check($sformatf("tlast[%0d]", j), 32'(sm_tlast), 32'(j == n-1));
            @(negedge axis_clk);
        end
        check("done_pulse", 32'(ap_done), 1);
        check("ready_after", 32'(ss_tready), 0);
        sm_tready = 1'b0;
    endtask

    task automatic run_stream(input int n, input int gap, input bit bp,
                              input bit sw, input bit probe);
        int exp_y[$];
        int d0;
        logic [31:0] st;
        for (int i = 0; i < n; i++) exp_y.push_back(fir_ref(i));
        d0 = done_cnt;
        start_pulse(sw);
        fork
            drive_in(n, gap);
            collect_out(exp_y, bp);
            if (probe) begin
                repeat (200) @(negedge axis_clk);
                axil_read(12'h000, st);
                check("run_stat", st & 32'hF, 32'h0);
            end
        join
        @(negedge axis_clk);
        check("done_cnt", done_cnt - d0, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic        seen;

        repeat (3) @(negedge axis_clk);
        check("rst_hs", {24'h0, arready, rvalid, awready, wready,
                         ss_tready, sm_tvalid, sm_tlast, ap_done}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_tdata", sm_tdata, 0);
        axis_rst_n = 1'b1;
        repeat (2) @(negedge axis_clk);
        axil_read(12'h000, d); check("stat_rst", d, 32'h4);
        axil_read(12'h02A, d); check("tap10_rst", d, 0);

        h = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        axil_write(12'h010, 600);
        for (int k = 0; k < NT; k++) axil_write(12'h020 + 12'(k), h[k]);
        for (int k = 0; k < NT; k++) begin
            axil_read(12'h020 + 12'(k), d);
            check($sformatf("tap%0d", k), d, h[k]);
        end
        axil_read(12'h010, d); check("len", d, 600);
        axil_read(12'h030, d); check("unmapped", d, 0);

        ss_tvalid = 1'b1; ss_tdata = 32'd1; seen = 1'b0;
        repeat (8) begin @(negedge axis_clk); seen |= ss_tready; end
        check("pre_start_rdy", 32'(seen), 0);

        // impulse: outputs are the taps, then zero
        axil_write(12'h010, 12);
        stim.delete();
        stim.push_back(1);
        for (int i = 1; i < 12; i++) stim.push_back(0);
        run_stream(12, 0, 1'b0, 1'b0, 1'b0);

        // triangular wave, software start, mid-run status probe
        axil_write(12'h010, 600);
        stim.delete();
        for (int i = 0; i < 600; i++) begin
            int v = i % 64;
            stim.push_back((v < 32 ? v : 64 - v) * 40 - 640);
        end
        run_stream(600, 2, 1'b1, 1'b1, 1'b1);
        axil_read(12'h000, d); check("stat_end", d, 32'h4);

        // full-range random taps and samples exercise wraparound
        for (int k = 0; k < NT; k++) begin
            h[k] = int'($urandom);
            axil_write(12'h020 + 12'(k), h[k]);
        end
        axil_write(12'h010, 40);
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(int'($urandom));
        run_stream(40, 3, 1'b1, 1'b0, 1'b0);

        // back-to-back throughput
        axil_write(12'h010, 4);
        stim.delete();
        for (int i = 0; i < 4; i++) stim.push_back(int'($urandom_range(0, 999)));
        hs_cyc.delete();
        run_stream(4, 0, 1'b0, 1'b0, 1'b0);
        check("hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() >= 3) begin
            check("period1", 32'(hs_cyc[1] - hs_cyc[0]), 13);
            check("period2", 32'(hs_cyc[2] - hs_cyc[1]), 13);
        end

        // zero length: immediate done, no stream traffic
        axil_write(12'h010, 0);
        start_pulse(1'b0);
        check("len0_done", 32'(ap_done), 1);
        check("len0_rdy", 32'(ss_tready), 0);
        @(negedge axis_clk);
        check("len0_pulse", 32'(ap_done), 0);
        axil_read(12'h000, d); check("len0_stat", d, 32'h4);

        // asynchronous reset in the middle of a run
        axil_write(12'h010, 600);
        start_pulse(1'b0);
        ss_tvalid = 1'b1; ss_tdata = 32'd7;
        repeat (20) @(negedge axis_clk);
        check("mid_valid", 32'(sm_tvalid), 1);
        #2 axis_rst_n = 1'b0;
        #1;
        check("arst_hs", {26'h0, ss_tready, sm_tvalid, sm_tlast,
                          ap_done, rvalid, arready}, 0);
        check("arst_tdata", sm_tdata, 0);
        ss_tvalid = 1'b0;
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        repeat (2) @(negedge axis_clk);
        axil_read(12'h000, d); check("arst_stat", d, 32'h4);
        axil_read(12'h023, d); check("arst_tap3", d, 0);
        axil_read(12'h010, d); check("arst_len", d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
